// File: rtl/hilo_mult_ctrl.sv
// hilo_mult_ctrl
//   Sequencer and HI/LO register owner in front of the 32-bit Booth multiply
//   engine. Accepts a multiply request, launches the engine, waits for its
//   result and commits the 64-bit product into HI/LO. Also services mthi/mtlo
//   writes (honoured only while idle) and exposes HI/LO for mfhi/mflo.
//
//   Optional feature macro: HILO_MULT_TIMEOUT_EN
//     defined   -> WAIT timeout timer, ABORT state, eng_stop and err pulses
//     undefined -> WAIT waits indefinitely, eng_stop/err tied to 0
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   req_valid/req_ready   multiply request handshake (req_ready = !busy)
//   req_a, req_b          operands
//   eng_init, eng_stop    one-cycle launch / abort pulses to the engine
//   eng_a, eng_b          latched operands, stable while busy
//   eng_done              engine result valid (sampled only in WAIT)
//   eng_hi, eng_lo        engine product halves
//   hi_we, lo_we, wdata   mthi/mtlo write strobes and data
//   hi, lo                HI/LO register contents
//   busy, done, err       status: not idle, commit pulse, timeout pulse

module hilo_mult_ctrl #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 40
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  output logic              eng_init,
  output logic              eng_stop,
  output logic [DATA_W-1:0] eng_a,
  output logic [DATA_W-1:0] eng_b,
  input  logic              eng_done,
  input  logic [DATA_W-1:0] eng_hi,
  input  logic [DATA_W-1:0] eng_lo,
  input  logic              hi_we,
  input  logic              lo_we,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              busy,
  output logic              done,
  output logic              err
);

`ifdef HILO_MULT_TIMEOUT_EN
  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_WAIT, S_COMMIT, S_ABORT
  } state_t;

  localparam int unsigned TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

  logic [TMR_W-1:0] timer;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_WAIT, S_COMMIT
  } state_t;

  assign eng_stop = 1'b0;
  assign err      = 1'b0;
`endif

  state_t state;

  assign req_ready = ~busy;

  // Status pulses are registered alongside the state transition that enters
  // the state they belong to, so each is high exactly for that state's cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      hi       <= '0;
      lo       <= '0;
      eng_a    <= '0;
      eng_b    <= '0;
      eng_init <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
`ifdef HILO_MULT_TIMEOUT_EN
      timer    <= '0;
      eng_stop <= 1'b0;
      err      <= 1'b0;
`endif
    end else begin
      eng_init <= 1'b0;
      done     <= 1'b0;
`ifdef HILO_MULT_TIMEOUT_EN
      eng_stop <= 1'b0;
      err      <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          // A move in the accept cycle lands now; the product overwrites it later.
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (req_valid) begin
            eng_a    <= req_a;
            eng_b    <= req_b;
            eng_init <= 1'b1;
            busy     <= 1'b1;
            state    <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
`ifdef HILO_MULT_TIMEOUT_EN
          timer <= '0;
`endif
          state <= S_WAIT;
        end
        S_WAIT: begin
          // Completion takes priority over a timer expiring in the same cycle.
          if (eng_done) begin
            hi    <= eng_hi;
            lo    <= eng_lo;
            done  <= 1'b1;
            state <= S_COMMIT;
          end
`ifdef HILO_MULT_TIMEOUT_EN
          else if (timer == TMR_LAST) begin
            eng_stop <= 1'b1;
            err      <= 1'b1;
            state    <= S_ABORT;
          end else begin
            timer <= timer + TMR_W'(1);
          end
`endif
        end
        S_COMMIT: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
`ifdef HILO_MULT_TIMEOUT_EN
        S_ABORT: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
`endif
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
